// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and byte width.
package uart_tx_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        LOAD       = 3'd2,
        WAIT_START = 3'd3,
        WAIT_EMPTY = 3'd4
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request bit strictly after ptr,
// wrapping modulo N_REQ; any flags that at least one request is set.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  cand_idx [N_REQ];

    // rot[gi] is the request gi+1 positions after the pointer; ptr+gi+1 < 2*N_REQ
    // so one conditional subtraction performs the wrap.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [ID_W:0] sum;
        assign sum          = {1'b0, ptr} + (ID_W+1)'(gi + 1);
        assign cand_idx[gi] = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                        : ID_W'(sum);
        assign rot[gi]      = req[cand_idx[gi]];
    end

    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = cand_idx[i];
            end
        end
    end

    assign any = |rot;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a single UART transmitter.
// Optional mid-packet idle release is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      ld_tx_data,
    output logic                      tx_enable,
    input  logic                      tx_empty,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      timeout
);

    localparam int ID_W = $clog2(N_REQ);

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     grant_reg;
    logic                last_reg;
    logic [BYTE_W-1:0]   tx_data_reg;

    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [BYTE_W-1:0]   req_byte [N_REQ];
    logic                gnt_valid;
    logic                accept;
    logic                timeout_hit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_picker (
        .req (req_valid),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign gnt_valid = req_valid[grant_reg];
    assign accept    = (state_reg == GRANT) && gnt_valid && tx_empty;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt_reg;

    // Counts GRANT cycles with the owner silent; release fires once it reaches the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if (state_reg != GRANT || accept || timeout_hit) begin
            idle_cnt_reg <= '0;
        end else if (!gnt_valid) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == GRANT) && !gnt_valid
                         && (idle_cnt_reg == CNT_W'(TIMEOUT_CYC));
`else
    assign timeout_hit = 1'b0 & (TIMEOUT_CYC < 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (pick_any) state_next = GRANT;
            GRANT: begin
                if (accept) begin
                    state_next = LOAD;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            LOAD:       state_next = WAIT_START;
            WAIT_START: state_next = WAIT_EMPTY;
            WAIT_EMPTY: if (tx_empty) state_next = last_reg ? IDLE : GRANT;
            default:    state_next = IDLE;
        endcase
    end

    // The captured byte doubles as the UART data register, so it only moves on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg     <= ID_W'(N_REQ - 1);
            grant_reg   <= '0;
            last_reg    <= 1'b0;
            tx_data_reg <= '0;
        end else begin
            if (state_reg == IDLE && pick_any) begin
                grant_reg <= pick_idx;
            end
            if (accept) begin
                tx_data_reg <= req_byte[grant_reg];
                last_reg    <= req_last[grant_reg];
            end
            if ((state_reg == WAIT_EMPTY && tx_empty && last_reg) || timeout_hit) begin
                ptr_reg <= grant_reg;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_reg] = 1'b1;
        end
        ld_tx_data = (state_reg == LOAD);
        busy       = (state_reg != IDLE);
        tx_enable  = (state_reg != IDLE);
        timeout    = timeout_hit;
    end

    assign tx_data  = tx_data_reg;
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte sources, a packet-level round-robin
// reference model, and scenario tasks that compare UART loads against it.
module tb_uart_tx_arbiter;

    localparam int N = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N-1:0]           req_valid;
    logic [8*N-1:0]         req_data;
    logic [N-1:0]           req_last;
    logic [N-1:0]           req_ready;
    logic [7:0]             tx_data;
    logic                   ld_tx_data;
    logic                   tx_enable;
    logic                   tx_empty;
    logic [$clog2(N)-1:0]   grant_id;
    logic                   busy;
    logic                   timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .ld_tx_data (ld_tx_data),
        .tx_enable  (tx_enable),
        .tx_empty   (tx_empty),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout    (timeout)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Byte sources: bit 8 is the last flag.
    logic [8:0] src_mem [N][1024];
    int         rd [N];
    int         wr [N];
    int         m_rd [N];
    logic [N-1:0] hold;
    int         model_ptr;

    logic [7:0] obs_q [$];
    int         ld_cyc [$];
    int         acc_q [$];
    logic [7:0] exp_q [$];
    logic       prev_busy = 1'b0;
    int         busy_fall_cyc = -1;

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (rd[k] < wr[k] && !hold[k]) begin
                req_valid[k]        = 1'b1;
                req_data[8*k +: 8]  = src_mem[k][rd[k]][7:0];
                req_last[k]         = src_mem[k][rd[k]][8];
            end else begin
                req_valid[k]        = 1'b0;
                req_data[8*k +: 8]  = 8'h00;
                req_last[k]         = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input logic last);
        src_mem[k][wr[k]] = {last, b};
        wr[k]++;
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) begin
            if (rd[k] < wr[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        ld_cyc.delete();
        acc_q.delete();
        exp_q.delete();
    endtask

    // One clock: sample on the falling edge, advance sources just after the rising edge.
    task automatic tick();
        logic [N-1:0] rdy;
        @(negedge clk);
        rdy = req_ready;
        if (ld_tx_data) begin
            obs_q.push_back(tx_data);
            ld_cyc.push_back(cyc);
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
        vectors++;
        if (($countones(rdy) > 1) || ((rdy & ~req_valid) != '0)) begin
            miscompares++;
            $display("FAIL ready_onehot: req_ready=%b with req_valid=%b, required one-hot within valid", rdy, req_valid);
        end
        for (int k = 0; k < N; k++) begin
            if (rdy[k]) acc_q.push_back(k);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (rdy[k]) rd[k]++;
        end
        refresh();
    endtask

    // Packet-level round robin: each turn goes to the next requester after the last owner
    // that still has bytes queued, and that requester sends a whole packet.
    task automatic model_expand();
        int   k;
        int   c;
        logic last;
        while (1) begin
            k = -1;
            for (int off = 1; off <= N; off++) begin
                c = (model_ptr + off) % N;
                if (k < 0 && m_rd[c] < wr[c]) k = c;
            end
            if (k < 0) break;
            last = 1'b0;
            while (!last && m_rd[k] < wr[k]) begin
                exp_q.push_back(src_mem[k][m_rd[k]][7:0]);
                last = src_mem[k][m_rd[k]][8];
                m_rd[k]++;
            end
            model_ptr = k;
        end
    endtask

    task automatic run_until_idle(input int max, input bit rand_empty);
        int n = 0;
        while ((pending() || busy) && n < max) begin
            if (rand_empty) tx_empty = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        tx_empty = 1'b1;
        tick();
        vectors++;
        if (n >= max) begin
            miscompares++;
            $display("FAIL drain_bound: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tx_empty = 1'b1;
        hold = '0;
        for (int k = 0; k < N; k++) begin
            rd[k] = wr[k];
            m_rd[k] = wr[k];
        end
        refresh();
        repeat (3) tick();
        rst_n = 1'b1;
        model_ptr = N - 1;
        clear_obs();
    endtask

    task automatic test_reset();
        hold = '0;
        tx_empty = 1'b1;
        for (int k = 0; k < N; k++) begin
            rd[k] = 0; wr[k] = 0; m_rd[k] = 0;
        end
        refresh();
        repeat (2) tick();
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rst_req_ready: got %b, required 000", req_ready); end
        vectors++; if (ld_tx_data !== 1'b0) begin miscompares++; $display("FAIL rst_ld_tx_data: got %b, required 0", ld_tx_data); end
        vectors++; if (tx_enable !== 1'b0) begin miscompares++; $display("FAIL rst_tx_enable: got %b, required 0", tx_enable); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b, required 0", timeout); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
        vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
        rst_n = 1'b1;
        model_ptr = N - 1;
        repeat (2) tick();
        vectors++; if (busy !== 1'b0 || ld_tx_data !== 1'b0) begin
            miscompares++; $display("FAIL idle_no_req: busy=%b ld=%b, required 0 0", busy, ld_tx_data);
        end
        clear_obs();
    endtask

    task automatic test_single();
        logic [7:0] exp3 [3];
        int c0;
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        clear_obs();
        c0 = cyc;
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        refresh();
        run_until_idle(200, 1'b0);
        vectors++;
        if (obs_q.size() != 3) begin
            miscompares++; $display("FAIL single_count: got %0d loads, required 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (obs_q[i] !== exp3[i]) begin miscompares++; $display("FAIL single_byte%0d: got %h, required %h", i, obs_q[i], exp3[i]); end
            end
            vectors++; if (ld_cyc[0] - c0 != 2) begin miscompares++; $display("FAIL single_first_latency: got %0d, required 2", ld_cyc[0] - c0); end
            vectors++; if (ld_cyc[1] - ld_cyc[0] != 4) begin miscompares++; $display("FAIL single_gap1: got %0d, required 4", ld_cyc[1] - ld_cyc[0]); end
            vectors++; if (ld_cyc[2] - ld_cyc[1] != 4) begin miscompares++; $display("FAIL single_gap2: got %0d, required 4", ld_cyc[2] - ld_cyc[1]); end
            vectors++; if (busy_fall_cyc != ld_cyc[2] + 3) begin miscompares++; $display("FAIL single_busy_fall: got cycle %0d, required %0d", busy_fall_cyc, ld_cyc[2] + 3); end
        end
        $display("single: %0d bytes loaded", obs_q.size());
    endtask

    task automatic test_uart_busy();
        int n = 0;
        int rise;
        clear_obs();
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b1);
        refresh();
        while (ld_cyc.size() == 0 && n < 20) begin tick(); n++; end
        vectors++;
        if (ld_cyc.size() == 0) begin
            miscompares++; $display("FAIL busy_first_load: got no load in %0d cycles, required one", n);
        end else begin
            tx_empty = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL busy_no_load: got %0d loads, required 1", obs_q.size()); end
                vectors++; if (tx_data !== 8'h11) begin miscompares++; $display("FAIL busy_tx_data: got %h, required 11", tx_data); end
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_held: got %b, required 1", busy); end
            end
            tx_empty = 1'b1;
            rise = cyc;
            run_until_idle(100, 1'b0);
            vectors++;
            if (ld_cyc.size() != 2) begin
                miscompares++; $display("FAIL busy_count: got %0d loads, required 2", ld_cyc.size());
            end else begin
                vectors++; if (ld_cyc[1] != rise + 2) begin miscompares++; $display("FAIL busy_resume: got cycle %0d, required %0d", ld_cyc[1], rise + 2); end
                vectors++; if (obs_q[1] !== 8'h22) begin miscompares++; $display("FAIL busy_byte2: got %h, required 22", obs_q[1]); end
            end
        end
        $display("uart_busy: %0d bytes loaded", obs_q.size());
    endtask

    task automatic test_contention();
        int gaps [7];
        gaps = '{4, 5, 4, 5, 4, 5, 4};
        apply_reset();
        push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b1);
        push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b1);
        push_byte(1, 8'hB0, 1'b0); push_byte(1, 8'hB1, 1'b1);
        push_byte(2, 8'hC0, 1'b0); push_byte(2, 8'hC1, 1'b1);
        model_expand();
        refresh();
        run_until_idle(300, 1'b0);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL cont_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL cont_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
            end
            for (int i = 0; i < 7; i++) begin
                vectors++; if (ld_cyc[i+1] - ld_cyc[i] != gaps[i]) begin miscompares++; $display("FAIL cont_gap%0d: got %0d, required %0d", i, ld_cyc[i+1] - ld_cyc[i], gaps[i]); end
            end
        end
        $display("contention: %0d bytes loaded", obs_q.size());
    endtask

    task automatic test_stall();
        int n = 0;
        int acc_exp [4];
        acc_exp = '{1, 1, 1, 2};
        clear_obs();
        push_byte(1, 8'hB0, 1'b0); push_byte(1, 8'hB1, 1'b0); push_byte(1, 8'hB2, 1'b1);
        refresh();
        while (acc_q.size() == 0 && n < 20) begin tick(); n++; end
        hold[1] = 1'b1;
        push_byte(2, 8'hC0, 1'b1);
        model_expand();
        refresh();
        for (int i = 0; i < 50; i++) begin
            tick();
            vectors++; if (acc_q.size() != 1) begin miscompares++; $display("FAIL stall_hold: got %0d accepts, required 1", acc_q.size()); end
        end
        hold[1] = 1'b0;
        refresh();
        run_until_idle(200, 1'b0);
        vectors++;
        if (acc_q.size() != 4 || obs_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL stall_count: got %0d accepts %0d loads, required 4 %0d", acc_q.size(), obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (acc_q[i] != acc_exp[i]) begin miscompares++; $display("FAIL stall_owner%0d: got req %0d, required req %0d", i, acc_q[i], acc_exp[i]); end
                vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stall_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
            end
        end
        $display("stall: %0d bytes loaded", obs_q.size());
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_obs();
        push_byte(1, 8'hD0, 1'b0); push_byte(1, 8'hD1, 1'b0); push_byte(1, 8'hD2, 1'b1);
        refresh();
        while (ld_cyc.size() == 0 && n < 20) begin tick(); n++; end
        tx_empty = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (ld_tx_data !== 1'b0 || busy !== 1'b0 || tx_enable !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_ctrl: ld=%b busy=%b en=%b, required 0 0 0", ld_tx_data, busy, tx_enable);
        end
        vectors++; if (req_ready !== 3'b000 || timeout !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_ready: ready=%b timeout=%b, required 000 0", req_ready, timeout);
        end
        vectors++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            miscompares++; $display("FAIL rstmid_data: tx_data=%h grant_id=%0d, required 00 0", tx_data, grant_id);
        end
        for (int k = 0; k < N; k++) begin
            rd[k] = wr[k];
            m_rd[k] = wr[k];
        end
        tx_empty = 1'b1;
        refresh();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (ld_tx_data !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_hold: ld=%b busy=%b, required 0 0", ld_tx_data, busy); end
        end
        rst_n = 1'b1;
        model_ptr = N - 1;
        clear_obs();
        push_byte(2, 8'hE0, 1'b1);
        push_byte(0, 8'hF0, 1'b1);
        push_byte(1, 8'h70, 1'b1);
        model_expand();
        refresh();
        run_until_idle(200, 1'b0);
        vectors++;
        if (acc_q.size() == 0 || acc_q[0] != 0) begin
            miscompares++; $display("FAIL rstmid_first_owner: got %0d accepts first=%0d, required first req 0", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : -1);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL rstmid_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
            end
        end
        $display("reset_mid: %0d bytes loaded after release", obs_q.size());
    endtask

    task automatic test_random();
        int npk, k, len;
        for (int r = 0; r < 4; r++) begin
            clear_obs();
            npk = $urandom_range(3, 8);
            for (int p = 0; p < npk; p++) begin
                k = $urandom_range(0, N - 1);
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    push_byte(k, 8'($urandom), (b == len - 1));
                end
            end
            model_expand();
            refresh();
            run_until_idle(3000, 1'b1);
            vectors++;
            if (obs_q.size() != exp_q.size()) begin
                miscompares++; $display("FAIL rand%0d_count: got %0d, required %0d", r, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_byte%0d: got %h, required %h", r, i, obs_q[i], exp_q[i]); end
                    if (i > 0) begin
                        vectors++; if (ld_cyc[i] - ld_cyc[i-1] < 4) begin miscompares++; $display("FAIL rand%0d_gap%0d: got %0d, required >=4", r, i, ld_cyc[i] - ld_cyc[i-1]); end
                    end
                end
            end
            $display("random round %0d: %0d packets, %0d bytes loaded", r, npk, obs_q.size());
        end
    endtask

    initial begin
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_empty = 1'b1;
        hold = '0;
        test_reset();
        test_single();
        test_uart_busy();
        test_contention();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
